// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings,
// controller states, response error codes and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_FUNCT3   = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } lsu_err_t;

  // Illegal funct3 is reported ahead of misalignment when both apply.
  function automatic lsu_err_t check_req(input logic store,
                                         input logic [2:0] f3,
                                         input logic [1:0] off);
    logic legal;
    logic misaligned;
    case (f3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~store;
      default:          legal = 1'b0;
    endcase
    // Size lives in f3[1:0]: 01 is halfword, 10 is word.
    misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                 ((f3[1:0] == 2'b10) && (off != 2'b00));
    if (!legal)
      return ERR_FUNCT3;
    else if (misaligned)
      return ERR_MISALIGN;
    else
      return ERR_NONE;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables, lane-replicated store data and
// right-aligned, sign/zero-extended load data for a word-wide memory.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  assign shifted = rdata_raw >> {off, 3'b000};

  // Byte enables and replicated store data follow the access size.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
      end
      2'b10: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = wdata;
      end
    endcase
  end

  // Load extension; a word is always aligned so the shift leaves it untouched.
  always_comb begin
    rdata_ext = 32'h0;
    case (funct3)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rdata_ext = shifted;
      F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
      F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
      default: rdata_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// One-at-a-time load/store sequencer between the core and a word-wide data
// memory: request checking, memory handshake with timeout, response hold.
module lsu_controller
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state_reg;
  logic        store_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [CW-1:0] cnt_reg;
  logic [31:0] rdata_reg;
  lsu_err_t    err_reg;
  logic        req_ready_reg;
  logic        resp_valid_reg;
  logic        mem_req_reg;
  logic        mem_we_reg;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  lsu_err_t    req_err;

  assign req_err = check_req(req_store, req_funct3, req_addr[1:0]);

  lsu_lane_align u_lane_align (
    .funct3    (funct3_reg),
    .off       (addr_reg[1:0]),
    .wdata     (wdata_reg),
    .rdata_raw (mem_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;
  assign mem_req    = mem_req_reg;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = {addr_reg[31:2], 2'b00};
  // Enables are only shown while the strobe is up, so reset clears them too.
  assign mem_be     = mem_req_reg ? lane_be : 4'b0000;
  assign mem_wdata  = lane_wdata;

  // Request/response FSM with registered handshake and memory strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      store_reg      <= 1'b0;
      funct3_reg     <= 3'b000;
      addr_reg       <= 32'h0;
      wdata_reg      <= 32'h0;
      cnt_reg        <= '0;
      rdata_reg      <= 32'h0;
      err_reg        <= ERR_NONE;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            store_reg     <= req_store;
            funct3_reg    <= req_funct3;
            addr_reg      <= req_addr;
            wdata_reg     <= req_wdata;
            req_ready_reg <= 1'b0;
            if (req_err != ERR_NONE) begin
              state_reg      <= DONE;
              err_reg        <= req_err;
              rdata_reg      <= 32'h0;
              resp_valid_reg <= 1'b1;
            end else begin
              state_reg   <= ACCESS;
              cnt_reg     <= '0;
              mem_req_reg <= 1'b1;
              mem_we_reg  <= req_store;
            end
          end
        end
        ACCESS: begin
          // The ack is checked first so it beats a timeout on the same cycle.
          if (mem_ack) begin
            state_reg      <= DONE;
            err_reg        <= ERR_NONE;
            rdata_reg      <= store_reg ? 32'h0 : lane_rdata;
            resp_valid_reg <= 1'b1;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            state_reg      <= DONE;
            err_reg        <= ERR_TIMEOUT;
            rdata_reg      <= 32'h0;
            resp_valid_reg <= 1'b1;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state_reg      <= IDLE;
            resp_valid_reg <= 1'b0;
            req_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg      <= IDLE;
          req_ready_reg  <= 1'b1;
          resp_valid_reg <= 1'b0;
          mem_req_reg    <= 1'b0;
          mem_we_reg     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller with a short timeout so the abort path
// is reachable in a few cycles.
module tb_lsu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_controller #(.TIMEOUT(4), .CW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; the controller must be ready to take it.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    req_valid  = 1'b1;
    check({tag, ".req_ready"}, {31'h0, req_ready}, 32'h1);
    step();
    req_valid = 1'b0;
  endtask

  // Consume the response and confirm the controller is back in IDLE.
  task automatic retire(input string tag);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({tag, ".idle_ready"}, {31'h0, req_ready}, 32'h1);
    check({tag, ".idle_resp_valid"}, {31'h0, resp_valid}, 32'h0);
  endtask

  // Single zero-wait load: checks the access and the extended result.
  task automatic load_once(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] raw,
                           input logic [3:0] exp_be, input logic [31:0] exp_rd, input string tag);
    issue(1'b0, f3, a, 32'h0, tag);
    check({tag, ".mem_req"}, {31'h0, mem_req}, 32'h1);
    check({tag, ".mem_be"}, {28'h0, mem_be}, {28'h0, exp_be});
    mem_ack   = 1'b1;
    mem_rdata = raw;
    step();
    mem_ack = 1'b0;
    check({tag, ".resp_valid"}, {31'h0, resp_valid}, 32'h1);
    check({tag, ".rdata"}, resp_rdata, exp_rd);
    check({tag, ".err"}, {30'h0, resp_err}, 32'h0);
    $display("txn %s addr=%h rdata=%h err=%0d", tag, a, resp_rdata, resp_err);
    retire(tag);
  endtask

  // Request rejected at accept: DONE next cycle with the error, no memory strobe.
  task automatic reject(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [1:0] exp_err, input string tag);
    issue(st, f3, a, 32'hFFFF_FFFF, tag);
    check({tag, ".no_mem_req"}, {31'h0, mem_req}, 32'h0);
    check({tag, ".resp_valid"}, {31'h0, resp_valid}, 32'h1);
    check({tag, ".err"}, {30'h0, resp_err}, {30'h0, exp_err});
    check({tag, ".rdata"}, resp_rdata, 32'h0);
    $display("txn %s addr=%h err=%0d", tag, a, resp_err);
    retire(tag);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    step();
    step();
    check("rst.req_ready", {31'h0, req_ready}, 32'h1);
    check("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst.mem_req", {31'h0, mem_req}, 32'h0);
    check("rst.mem_we", {31'h0, mem_we}, 32'h0);
    check("rst.mem_be", {28'h0, mem_be}, 32'h0);
    check("rst.rdata", resp_rdata, 32'h0);
    check("rst.err", {30'h0, resp_err}, 32'h0);
    reset = 1'b0;
    step();

    // LW, zero-wait: ACCESS in cycle 1, response in cycle 2.
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0, "lw");
    check("lw.mem_req", {31'h0, mem_req}, 32'h1);
    check("lw.mem_we", {31'h0, mem_we}, 32'h0);
    check("lw.mem_addr", mem_addr, 32'h0000_0100);
    check("lw.mem_be", {28'h0, mem_be}, 32'hF);
    check("lw.resp_valid_c1", {31'h0, resp_valid}, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    check("lw.resp_valid", {31'h0, resp_valid}, 32'h1);
    check("lw.rdata", resp_rdata, 32'hDEAD_BEEF);
    check("lw.err", {30'h0, resp_err}, 32'h0);
    check("lw.mem_req_done", {31'h0, mem_req}, 32'h0);
    check("lw.req_ready_done", {31'h0, req_ready}, 32'h0);
    $display("txn lw addr=00000100 rdata=%h err=%0d", resp_rdata, resp_err);
    retire("lw");

    // Byte and halfword loads from upper lanes.
    load_once(3'b000, 32'h0000_0103, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80, "lb");
    load_once(3'b100, 32'h0000_0103, 32'h8012_3456, 4'b1000, 32'h0000_0080, "lbu");
    load_once(3'b001, 32'h0000_0102, 32'hF00D_1234, 4'b1100, 32'hFFFF_F00D, "lh");
    load_once(3'b101, 32'h0000_0102, 32'hF00D_1234, 4'b1100, 32'h0000_F00D, "lhu");
    load_once(3'b000, 32'h0000_0101, 32'h0000_7F00, 4'b0010, 32'h0000_007F, "lb_pos");

    // SH at offset 2: replicated halfword, upper lanes enabled, word address.
    issue(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, "sh");
    check("sh.mem_req", {31'h0, mem_req}, 32'h1);
    check("sh.mem_we", {31'h0, mem_we}, 32'h1);
    check("sh.mem_be", {28'h0, mem_be}, 32'hC);
    check("sh.mem_wdata", mem_wdata, 32'hABCD_ABCD);
    check("sh.mem_addr", mem_addr, 32'h0000_0200);
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_5555;
    step();
    mem_ack = 1'b0;
    check("sh.resp_valid", {31'h0, resp_valid}, 32'h1);
    check("sh.rdata", resp_rdata, 32'h0);
    check("sh.err", {30'h0, resp_err}, 32'h0);
    $display("txn sh addr=00000202 err=%0d", resp_err);
    retire("sh");

    // SB at offset 1: replicated byte, single lane.
    issue(1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, "sb");
    check("sb.mem_be", {28'h0, mem_be}, 32'h2);
    check("sb.mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("sb.mem_addr", mem_addr, 32'h0000_0300);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("sb.err", {30'h0, resp_err}, 32'h0);
    $display("txn sb addr=00000301 err=%0d", resp_err);
    retire("sb");

    // Rejected requests.
    reject(1'b0, 3'b010, 32'h0000_0101, 2'b01, "lw_mis");
    reject(1'b0, 3'b001, 32'h0000_0103, 2'b01, "lh_mis");
    reject(1'b1, 3'b100, 32'h0000_0100, 2'b10, "sb_f3");
    reject(1'b0, 3'b011, 32'h0000_0001, 2'b10, "lh_f3_mis");
    reject(1'b1, 3'b101, 32'h0000_0001, 2'b10, "shu_f3_mis");

    // Timeout: exactly 4 ACCESS cycles without ack, then err=11 and rdata=0.
    mem_rdata = 32'h1234_5678;
    issue(1'b0, 3'b010, 32'h0000_0400, 32'h0, "to");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to.mem_req_c%0d", i), {31'h0, mem_req}, 32'h1);
      check($sformatf("to.resp_valid_c%0d", i), {31'h0, resp_valid}, 32'h0);
      step();
    end
    check("to.resp_valid", {31'h0, resp_valid}, 32'h1);
    check("to.err", {30'h0, resp_err}, 32'h3);
    check("to.rdata", resp_rdata, 32'h0);
    check("to.mem_req_off", {31'h0, mem_req}, 32'h0);
    $display("txn timeout addr=00000400 err=%0d", resp_err);
    retire("to");

    // Ack on the last allowed cycle wins over the timeout.
    issue(1'b0, 3'b010, 32'h0000_0404, 32'h0, "late");
    for (int i = 0; i < 3; i++) step();
    check("late.mem_req_c3", {31'h0, mem_req}, 32'h1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1122_3344;
    step();
    mem_ack = 1'b0;
    check("late.err", {30'h0, resp_err}, 32'h0);
    check("late.rdata", resp_rdata, 32'h1122_3344);
    $display("txn late_ack addr=00000404 rdata=%h err=%0d", resp_rdata, resp_err);
    retire("late");

    // Reset mid-ACCESS drops the strobe immediately and no response follows.
    issue(1'b0, 3'b010, 32'h0000_0500, 32'h0, "rst_mid");
    check("rst_mid.mem_req_pre", {31'h0, mem_req}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid.mem_req_async", {31'h0, mem_req}, 32'h0);
    check("rst_mid.mem_be_async", {28'h0, mem_be}, 32'h0);
    step();
    reset   = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_mid.resp_valid_c%0d", i), {31'h0, resp_valid}, 32'h0);
      check($sformatf("rst_mid.req_ready_c%0d", i), {31'h0, req_ready}, 32'h1);
    end
    mem_ack = 1'b0;
    $display("txn reset_mid_access resp_valid=%0d", resp_valid);

    // DONE holds with resp_ready low.
    issue(1'b0, 3'b010, 32'h0000_0102, 32'h0, "hold");
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold.resp_valid_c%0d", i), {31'h0, resp_valid}, 32'h1);
      check($sformatf("hold.err_c%0d", i), {30'h0, resp_err}, 32'h1);
      check($sformatf("hold.req_ready_c%0d", i), {31'h0, req_ready}, 32'h0);
      check($sformatf("hold.rdata_c%0d", i), resp_rdata, 32'h0);
    end
    mem_ack = 1'b0;
    $display("txn hold err=%0d", resp_err);
    retire("hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
